// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, mode encodings and BCD limits for the time-of-day clock
//
// Purpose : common definitions imported by bcd_mod_counter and bcd_time_counter.
// Contents: mode_e (RUN / SET_HOUR / SET_MIN, plus the unreachable code 3),
//           bcd2_t (two packed BCD digits), field limits, BCD increment helper.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2,
      MODE_ILLEGAL  = 2'd3
   } mode_e;

   // [7:4] tens digit, [3:0] units digit
   typedef logic [7:0] bcd2_t;

   localparam bcd2_t HOUR_MAX = 8'h23;
   localparam bcd2_t MIN_MAX  = 8'h59;
   localparam bcd2_t SEC_MAX  = 8'h59;

   // Plain two-digit BCD +1; wrap at the field limit is handled by the caller.
   function automatic bcd2_t bcd_inc(input bcd2_t v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping from MAX to 00
//
// Purpose : one time field (seconds, minutes or hours).
// Ports   : clk   - clock
//           rst   - synchronous active-high reset, value 00
//           inc   - advance by one this edge
//           clr   - force 00 this edge (wins over inc)
//           q     - current value, registered
//           carry - combinational, high when inc is applied while q == MAX
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter bcd2_t MAX = 8'h59
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  inc,
   input  logic  clr,
   output bcd2_t q,
   output logic  carry
);

   bcd2_t q_q;
   bcd2_t q_d;

   assign carry = inc && (q_q == MAX);
   assign q     = q_q;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = 8'h00;
      end else if (inc) begin
         q_d = carry ? 8'h00 : bcd_inc(q_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= 8'h00;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - 1 Hz prescaler, HH:MM:SS BCD time keeping and set-mode FSM
//
// Purpose : time-of-day source; divides clk to a seconds tick and lets the user set
//           hours and minutes with a mode/increment button pair.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           btn_mode, btn_inc   - single-cycle debounced button pulses
//           cur_hour/min/sec    - packed BCD time, registered
//           mode                - 0 RUN, 1 SET_HOUR, 2 SET_MIN
//           sec_tick            - pulse in the first cycle a RUN-mode advance is visible
//           day_wrap            - pulse in the first cycle 00:00:00 is visible after 23:59:59
module bcd_time_counter
   import clock_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [7:0] cur_hour,
   output logic [7:0] cur_min,
   output logic [7:0] cur_sec,
   output logic [1:0] mode,
   output logic       sec_tick,
   output logic       day_wrap
);

   localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

   mode_e         mode_q, mode_d;
   logic [PW-1:0] ps_q, ps_d;
   logic          sec_tick_q, day_wrap_q;

   logic run;
   logic tick;
   logic exit_set;
   logic edit_inc;
   logic sec_carry, min_carry, hour_carry;
   logic sec_inc, min_inc, hour_inc;

   assign run      = (mode_q == MODE_RUN);
   assign tick     = run && (ps_q == PS_LAST);
   // Leaving SET_MIN restarts the second so the user's set minute begins cleanly.
   assign exit_set = (mode_q == MODE_SET_MIN) && btn_mode;
   // A mode step in the same cycle swallows the increment.
   assign edit_inc = btn_inc && !btn_mode;

   // Carries only ripple from the tick; edits never carry into the next field.
   assign sec_inc  = tick;
   assign min_inc  = (tick && sec_carry) || ((mode_q == MODE_SET_MIN) && edit_inc);
   assign hour_inc = (tick && sec_carry && min_carry) || ((mode_q == MODE_SET_HOUR) && edit_inc);

   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         MODE_RUN:      if (btn_mode) mode_d = MODE_SET_HOUR;
         MODE_SET_HOUR: if (btn_mode) mode_d = MODE_SET_MIN;
         MODE_SET_MIN:  if (btn_mode) mode_d = MODE_RUN;
         default:       mode_d = MODE_RUN;
      endcase
   end

   // Held at zero outside RUN so the first tick after an edit is a full period away.
   always_comb begin
      ps_d = '0;
      if (run && !tick) begin
         ps_d = ps_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= MODE_RUN;
         ps_q       <= '0;
         sec_tick_q <= 1'b0;
         day_wrap_q <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         ps_q       <= ps_d;
         sec_tick_q <= tick;
         day_wrap_q <= tick && sec_carry && min_carry && hour_carry;
      end
   end

   bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst   (rst),
      .inc   (sec_inc),
      .clr   (exit_set),
      .q     (cur_sec),
      .carry (sec_carry)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
      .clk   (clk),
      .rst   (rst),
      .inc   (min_inc),
      .clr   (1'b0),
      .q     (cur_min),
      .carry (min_carry)
   );

   bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk   (clk),
      .rst   (rst),
      .inc   (hour_inc),
      .clr   (1'b0),
      .q     (cur_hour),
      .carry (hour_carry)
   );

   assign mode     = mode_q;
   assign sec_tick = sec_tick_q;
   assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - self-checking bench for bcd_time_counter
module tb_bcd_time_counter;

   localparam int CLK_HZ = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode;
   logic       btn_inc;
   logic [7:0] cur_hour;
   logic [7:0] cur_min;
   logic [7:0] cur_sec;
   logic [1:0] mode;
   logic       sec_tick;
   logic       day_wrap;

   always #5 clk = ~clk;

   bcd_time_counter #(.CLK_HZ(CLK_HZ)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .cur_hour (cur_hour),
      .cur_min  (cur_min),
      .cur_sec  (cur_sec),
      .mode     (mode),
      .sec_tick (sec_tick),
      .day_wrap (day_wrap)
   );

   typedef struct packed {
      logic [7:0] hour;
      logic [7:0] min;
      logic [7:0] sec;
      logic [1:0] md;
      logic       st;
      logic       dw;
   } exp_t;

   typedef struct {
      bit   bm;
      bit   bi;
      bit   r;
      exp_t e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[32];
   int   checks = 0;
   int   passed = 0;

   // Reference model state in plain integers.
   int mh, mm, ms, mmd, mpc;
   bit mst, mdw;

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   function automatic exp_t mk(input int h, input int m, input int s, input int md,
                               input bit st, input bit dw);
      exp_t e;
      e.hour = bcd(h);
      e.min  = bcd(m);
      e.sec  = bcd(s);
      e.md   = 2'(md);
      e.st   = st;
      e.dw   = dw;
      return e;
   endfunction

   task automatic model_step(input bit bm, input bit bi, input bit r);
      bit tk;
      if (r) begin
         mh = 0; mm = 0; ms = 0; mmd = 0; mpc = 0; mst = 0; mdw = 0;
      end else begin
         tk  = (mmd == 0) && (mpc == CLK_HZ - 1);
         mst = tk;
         mdw = 0;
         mpc = (mmd == 0 && !tk) ? mpc + 1 : 0;
         if (tk) begin
            ms = ms + 1;
            if (ms == 60) begin
               ms = 0; mm = mm + 1;
               if (mm == 60) begin
                  mm = 0; mh = mh + 1;
                  if (mh == 24) begin
                     mh = 0; mdw = 1;
                  end
               end
            end
         end
         if (bm) begin
            if (mmd == 0) mmd = 1;
            else if (mmd == 1) mmd = 2;
            else begin
               mmd = 0; ms = 0;
            end
         end else if (bi) begin
            if (mmd == 1) mh = (mh + 1) % 24;
            else if (mmd == 2) mm = (mm + 1) % 60;
         end
      end
   endtask

   task automatic check_all(input string name, input exp_t got, input exp_t exp);
      checks++;
      if (got === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h:%h:%h mode=%0d tick=%b wrap=%b, expected %h:%h:%h mode=%0d tick=%b wrap=%b",
                  name, got.hour, got.min, got.sec, got.md, got.st, got.dw,
                  exp.hour, exp.min, exp.sec, exp.md, exp.st, exp.dw);
      end
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   // Drive inputs just after a falling edge, push the expectation, sample at the next falling edge.
   task automatic drive(input bit bm, input bit bi, input bit r, input exp_t e, input string name);
      exp_t got;
      btn_mode = bm;
      btn_inc  = bi;
      rst      = r;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      got = {cur_hour, cur_min, cur_sec, mode, sec_tick, day_wrap};
      if (sb.size() == 0) begin
         checks++;
         $display("FAIL %s: scoreboard empty, got %h, expected an entry", name, got);
      end else begin
         check_all(name, got, sb.pop_front());
      end
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic step(input bit bm, input bit bi, input bit r, input string name);
      model_step(bm, bi, r);
      drive(bm, bi, r, mk(mh, mm, ms, mmd, mst, mdw), name);
   endtask

   // RUN-mode cycles with random btn_inc, which must be ignored.
   task automatic run_cycles(input int n, input string name, output int wraps);
      wraps = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'b0, name);
         if (day_wrap) wraps++;
      end
   endtask

   initial begin
      int w;
      rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
      @(negedge clk);

      // Reset and first tick
      step(0, 0, 1, "reset");
      chk("reset_hour", cur_hour, 8'h00);
      chk("reset_mode", mode, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, "pre_tick");
      chk("pre_tick_sec", cur_sec, 8'h00);
      step(0, 0, 0, "first_tick");
      chk("first_tick_sec", cur_sec, 8'h01);
      chk("first_tick_pulse", sec_tick, 1);

      // BCD units carry and seconds -> minutes carry
      run_cycles(8 * CLK_HZ, "run_to_09", w);
      chk("sec_09", cur_sec, 8'h09);
      run_cycles(CLK_HZ, "run_to_10", w);
      chk("sec_10", cur_sec, 8'h10);
      run_cycles(49 * CLK_HZ, "run_to_59", w);
      chk("sec_59", cur_sec, 8'h59);
      run_cycles(CLK_HZ, "run_to_min", w);
      chk("min_carry_min", cur_min, 8'h01);
      chk("min_carry_sec", cur_sec, 8'h00);

      // btn_mode on the tick cycle: tick applied and mode steps
      for (int i = 0; i < CLK_HZ - 1; i++) step(0, 0, 0, "pre_mode_tick");
      step(1, 0, 0, "mode_on_tick");
      chk("mode_on_tick_sec", cur_sec, 8'h01);
      chk("mode_on_tick_mode", mode, 1);

      // Set 23:59, exit, and run 60 ticks to midnight
      for (int i = 0; i < 23; i++) step(0, 1, 0, "set_hour_23");
      step(1, 0, 0, "to_set_min");
      for (int i = 0; i < 58; i++) step(0, 1, 0, "set_min_59");
      step(1, 0, 0, "exit_set");
      chk("exit_sec_cleared", cur_sec, 8'h00);
      chk("exit_hour", cur_hour, 8'h23);
      run_cycles(60 * CLK_HZ, "to_midnight", w);
      chk("day_wrap_count", w, 1);
      chk("midnight_hour", cur_hour, 8'h00);
      chk("midnight_min", cur_min, 8'h00);

      // Table-driven: SET_HOUR sweep, combined buttons, exit
      vecs[0] = '{bm: 0, bi: 0, r: 1, e: mk(0, 0, 0, 0, 0, 0)};
      vecs[1] = '{bm: 1, bi: 0, r: 0, e: mk(0, 0, 0, 1, 0, 0)};
      for (int i = 1; i <= 24; i++) vecs[1 + i] = '{bm: 0, bi: 1, r: 0, e: mk(i % 24, 0, 0, 1, 0, 0)};
      for (int i = 1; i <= 3; i++) vecs[25 + i] = '{bm: 0, bi: 1, r: 0, e: mk(i, 0, 0, 1, 0, 0)};
      vecs[29] = '{bm: 1, bi: 1, r: 0, e: mk(3, 0, 0, 2, 0, 0)};
      vecs[30] = '{bm: 0, bi: 1, r: 0, e: mk(3, 1, 0, 2, 0, 0)};
      vecs[31] = '{bm: 1, bi: 0, r: 0, e: mk(3, 1, 0, 0, 0, 0)};
      for (int i = 0; i < 32; i++) begin
         model_step(vecs[i].bm, vecs[i].bi, vecs[i].r);
         drive(vecs[i].bm, vecs[i].bi, vecs[i].r, vecs[i].e, $sformatf("vec%0d", i));
      end

      // Reset in SET_MIN with btn_inc high
      step(1, 0, 0, "to_set_hour2");
      step(1, 0, 0, "to_set_min2");
      step(0, 1, 0, "set_min_inc2");
      step(0, 1, 1, "rst_mid_set");
      chk("rst_mid_set_min", cur_min, 8'h00);
      chk("rst_mid_set_mode", mode, 0);
      chk("rst_mid_set_tick", sec_tick, 0);
      run_cycles(2 * CLK_HZ, "after_rst", w);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
